mem_stage_lsu: RTL
==================

Name: mem_stage_lsu

Overview:
Memory-stage load/store unit; consumes the EX/MEM pipeline register outputs and drives the data bus (DM and bridge) through a req/ack handshake.
Generates byte enables and replicated store data, sign/zero-extends load data, and detects misaligned addresses (AdEL/AdES).
Stalls the pipeline while a bus access is outstanding; times out hung slaves with a bus-error flag.
Feeds loaded data toward MEM/WB and exception flags toward CP0.

Parameters:
TIMEOUT, 16, ACCESS-state cycles without bus_ack before bus error (>=1)
CNT_W, 5, timeout counter width (must hold TIMEOUT)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
IntBeq  in  1  flush from interrupt/branch; suppresses starting a new access
load  in  1  instruction in MEM is a load
sb  in  1  store byte
sh  in  1  store half
sw  in  1  store word
load_ext_op  in  3  0 lw, 1 lbu, 2 lb, 3 lhu, 4 lh; 5-7 treated as lw
ALUS  in  32  effective address
DMSaveData  in  32  store data (rt)
bus_rdata  in  32  read data, valid with bus_ack
bus_ack  in  1  slave completion, sampled only in ACCESS
bus_req  out  1  access request
bus_we  out  1  1 store, 0 load
bus_addr  out  32  word-aligned address {addr[31:2],2'b00}
bus_be  out  4  byte enables, bit i = byte addr[1:0]==i
bus_wdata  out  32  replicated store data
mem_stall  out  1  hold IF..EX/MEM (combinational)
load_data  out  32  extended load result (registered)
load_valid  out  1  one-cycle pulse: load_data updated
exc_adel  out  1  misaligned load (combinational, same cycle)
exc_ades  out  1  misaligned store (combinational, same cycle)
exc_bus_err  out  1  one-cycle pulse, registered, on timeout

Behaviour:
- Reset: state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, load_data=0, load_valid=0, exc_bus_err=0, counter=0. rst has priority over everything, including a mid-access state; the pending access is dropped with no ack wait.
- acc = load|sb|sh|sw.
- mis = (lw|sw) & addr[1:0]!=0, or (lh|lhu|sh) & addr[0]!=0. Byte ops are never misaligned.
- exc_adel = load & mis & !IntBeq & state==IDLE. exc_ades = store & mis & !IntBeq & state==IDLE.
- start = acc & !mis & !IntBeq & state==IDLE.
- IDLE state:
  - On start: mem_stall=1.
  - At the clock edge: latch bus_addr, bus_we, bus_be, bus_wdata, addr[1:0] and the ext op; go to ACCESS; counter=0.
  - A misaligned access never stalls and never issues bus_req.
- ACCESS state:
  - bus_req=1; mem_stall = !bus_ack.
  - On bus_ack: load_data = extended bus_rdata and load_valid=1 next cycle (loads only); return to IDLE.
  - Minimum cost per access is 1 stall cycle. Same-cycle (combinational) ack is legal.
  - Without ack: counter increments each cycle. After TIMEOUT cycles: bus_req drops, exc_bus_err pulses, return to IDLE, mem_stall drops in the same cycle as the timeout decision.
  - IntBeq asserted during ACCESS does not abort the transaction. A store already issued completes.
- Byte enables:
  - sw/lw: 1111.
  - sh/lh/lhu: addr[1] ? 1100 : 0011.
  - sb/lb/lbu: 0001 << addr[1:0].
- Store data:
  - sb: {4{DMSaveData[7:0]}}.
  - sh: {2{DMSaveData[15:0]}}.
  - sw: DMSaveData.
  - Loads: bus_wdata=0.
- Load extension: select byte addr[1:0] (bits 8*a+7:8*a) or half addr[1] (bits 31:16 if 1). lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- Simultaneous load and store flags: load wins; bus_we=0.
- bus_addr, bus_be and bus_wdata are held stable for the whole ACCESS state.
- load_valid and exc_bus_err are single-cycle.

Test Plan:
- lw ALUS=0x10, ack on first ACCESS cycle, rdata=0xDEADBEEF -> mem_stall high 1 cycle, bus_be=1111, bus_addr=0x10; next cycle load_data=0xDEADBEEF, load_valid=1.
- lb ALUS=0x13, rdata=0x80123456 -> bus_be=1000, load_data=0xFFFFFF80. Repeat with lbu -> 0x00000080.
- sh ALUS=0x22, DMSaveData=0x1234ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD, bus_addr=0x20.
- lw ALUS=0x6 -> exc_adel=1 same cycle, bus_req never rises, mem_stall=0. sh ALUS=0x21 -> exc_ades=1.
- lw with bus_ack held 0 -> bus_req high exactly TIMEOUT cycles, then exc_bus_err one-cycle pulse, state IDLE, load_valid stays 0. Ack delayed 3 cycles -> mem_stall 4 cycles.
- rst asserted in 2nd ACCESS cycle -> next cycle bus_req=0, all outputs 0. IntBeq with load in IDLE -> no access, no exception.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu_if
// Purpose : data-bus handshake between the MEM-stage load/store unit and the
//           data memory / bridge slave.
// Signals : bus_req   access request (held for the whole access)
//           bus_we    1 store, 0 load
//           bus_addr  word-aligned byte address
//           bus_be    byte enables, bit i selects byte lane i
//           bus_wdata lane-replicated store data
//           bus_rdata read data, valid together with bus_ack
//           bus_ack   slave completion
// ---------------------------------------------------------------------------
interface mem_stage_lsu_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu
// Purpose : memory-stage load/store unit. Turns the EX/MEM register outputs
//           into a req/ack bus access, stalls the pipeline while it is
//           outstanding, extends load data and flags misaligned accesses and
//           hung slaves.
// Ports   : clk, rst          clock, synchronous active-high reset
//           i_intbeq          flush; blocks starting a new access
//           i_load/i_sb/i_sh/i_sw, i_load_ext_op   operation select
//           i_alus            effective address
//           i_dm_save_data    store data (rt)
//           bus               data bus, master side
//           o_mem_stall       combinational pipeline hold
//           o_load_data       registered extended load result
//           o_load_valid      one-cycle pulse when o_load_data updates
//           o_exc_adel/o_exc_ades  combinational misalignment exceptions
//           o_exc_bus_err     one-cycle registered timeout pulse
// ---------------------------------------------------------------------------
module mem_stage_lsu #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_intbeq,
  input  logic                  i_load,
  input  logic                  i_sb,
  input  logic                  i_sh,
  input  logic                  i_sw,
  input  logic [2:0]            i_load_ext_op,
  input  logic [31:0]           i_alus,
  input  logic [31:0]           i_dm_save_data,
  mem_stage_lsu_if.master       bus,
  output logic                  o_mem_stall,
  output logic [31:0]           o_load_data,
  output logic                  o_load_valid,
  output logic                  o_exc_adel,
  output logic                  o_exc_ades,
  output logic                  o_exc_bus_err
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Access size; a load flag overrides any store flag.
  function automatic logic [1:0] op_size(input logic ld, input logic sb, input logic sh,
                                         input logic sw, input logic [2:0] ext);
    logic [1:0] sz;
    if (ld) begin
      case (ext)
        3'd1, 3'd2: sz = SZ_BYTE;
        3'd3, 3'd4: sz = SZ_HALF;
        default:    sz = SZ_WORD;
      endcase
    end else if (sw) begin
      sz = SZ_WORD;
    end else if (sh) begin
      sz = SZ_HALF;
    end else begin
      sz = (sb) ? SZ_BYTE : SZ_WORD;
    end
    return sz;
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    logic m;
    case (sz)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = a[0];
      default: m = (a != 2'b00);
    endcase
    return m;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = 4'b0001 << a;
      SZ_HALF: be = (a[1]) ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w;
    case (sz)
      SZ_BYTE: w = {4{d[7:0]}};
      SZ_HALF: w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] ext_load(input logic [31:0] rd, input logic [2:0] ext,
                                           input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[{a, 3'b000} +: 8];
    h = (a[1]) ? rd[31:16] : rd[15:0];
    case (ext)
      3'd1:    r = {24'd0, b};
      3'd2:    r = {{24{b[7]}}, b};
      3'd3:    r = {16'd0, h};
      3'd4:    r = {{16{h[15]}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_bus_addr;
  logic              r_bus_we;
  logic [3:0]        r_bus_be;
  logic [31:0]       r_bus_wdata;
  logic [1:0]        r_a;
  logic [2:0]        r_ext;
  logic [31:0]       r_load_data;
  logic              r_load_valid;
  logic              r_bus_err;

  logic              w_acc;
  logic [1:0]        w_size;
  logic              w_mis;
  logic              w_idle;
  logic              w_start;
  logic              w_timeout;

  assign w_acc   = i_load | i_sb | i_sh | i_sw;
  assign w_size  = op_size(i_load, i_sb, i_sh, i_sw, i_load_ext_op);
  assign w_mis   = w_acc & misaligned(w_size, i_alus[1:0]);
  assign w_idle  = (r_state == ST_IDLE);
  assign w_start = w_acc & ~w_mis & ~i_intbeq & w_idle;

  // Exceptions only raise while no access is in flight; load has priority.
  assign o_exc_adel = i_load & w_mis & ~i_intbeq & w_idle;
  assign o_exc_ades = ~i_load & w_mis & ~i_intbeq & w_idle;

  assign bus.bus_req   = (r_state == ST_ACCESS);
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_be    = r_bus_be;
  assign bus.bus_wdata = r_bus_wdata;

  assign o_load_data   = r_load_data;
  assign o_load_valid  = r_load_valid;
  assign o_exc_bus_err = r_bus_err;

  // Next-state, stall and timeout decision.
  always_comb begin
    w_next      = r_state;
    w_timeout   = 1'b0;
    o_mem_stall = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_next      = ST_ACCESS;
          o_mem_stall = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (bus.bus_ack) begin
          w_next = ST_IDLE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          // Last waiting cycle: release the pipeline now, flag error next cycle.
          w_next    = ST_IDLE;
          w_timeout = 1'b1;
        end else begin
          o_mem_stall = 1'b1;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State, latched access attributes, load result and pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_bus_addr   <= 32'd0;
      r_bus_we     <= 1'b0;
      r_bus_be     <= 4'd0;
      r_bus_wdata  <= 32'd0;
      r_a          <= 2'd0;
      r_ext        <= 3'd0;
      r_load_data  <= 32'd0;
      r_load_valid <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_load_valid <= 1'b0;
      r_bus_err    <= w_timeout;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_bus_addr  <= {i_alus[31:2], 2'b00};
            r_bus_we    <= ~i_load;
            r_bus_be    <= byte_en(w_size, i_alus[1:0]);
            r_bus_wdata <= (i_load) ? 32'd0 : store_data(w_size, i_dm_save_data);
            r_a         <= i_alus[1:0];
            r_ext       <= i_load_ext_op;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt;
          end
        end
        ST_ACCESS: begin
          if (bus.bus_ack) begin
            if (!r_bus_we) begin
              r_load_data  <= ext_load(bus.bus_rdata, r_ext, r_a);
              r_load_valid <= 1'b1;
            end else begin
              r_load_data <= r_load_data;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

endmodule
